training_sequencer: RTL and testbench

Parametrised multi-weight training engine. Once per epoch it walks NUMBER_WEIGHTS weights in weight memory and applies a Manhattan (sign-step) update, new = old − sign(delta)·eta. It tracks the best squared error, halves eta when progress stalls, and terminates on a threshold or an epoch limit. It sits between the NN layer error output, the weight/gradient memory and one shared FloPoCo adder of fixed latency.

---
 rtl/training_sequencer_pkg.sv | 39 +++
 rtl/training_sequencer_lt.sv | 48 ++++
 rtl/training_sequencer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_training_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/training_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : training_sequencer_pkg                                        |
// | Purpose  : Shared definitions for the training sequencer: FloPoCo        |
// |            exception encodings, field widths, default word constants     |
// |            (+inf, initial eta) and the sequencer state encoding.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package training_sequencer_pkg;

    // FloPoCo values carry a 2-bit exception tag above the IEEE payload.
    localparam int EXC_W = 2;
    localparam int EXP_W = 8;

    localparam logic [EXC_W-1:0] EXC_ZERO   = 2'b00;
    localparam logic [EXC_W-1:0] EXC_NORMAL = 2'b01;
    localparam logic [EXC_W-1:0] EXC_INF    = 2'b10;
    localparam logic [EXC_W-1:0] EXC_NAN    = 2'b11;

    // Default geometry (32-bit payload + 2 exception bits).
    localparam int DEF_BIT_WIDTH = 32;
    localparam int DEF_EXTRA_BIT = 2;
    localparam int DEF_W         = DEF_BIT_WIDTH + DEF_EXTRA_BIT;

    localparam logic [DEF_W-1:0] FP_POS_INF  = {EXC_INF, 32'h0000_0000};
    localparam logic [DEF_W-1:0] FP_ETA_INIT = {EXC_NORMAL, 32'h3DCC_CCCD};  // 0.1

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_ERR = 3'd1,
        ST_READ     = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_WAIT_ADD = 3'd4,
        ST_WRITE    = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/training_sequencer_lt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : flopoco_lt                                                    |
// | Purpose  : Combinational a < b for non-negative FloPoCo values.          |
// |            Ordering: zero < normal < inf; normals compare by the         |
// |            exponent/mantissa field as an unsigned integer. NaN operands  |
// |            never compare less.                                           |
// | Ports    : a_i, b_i (W-bit operands) -> lt_o (1 when a_i < b_i)          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module flopoco_lt
    import training_sequencer_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int EXTRA_BIT = DEF_EXTRA_BIT
) (
    input  logic [BIT_WIDTH+EXTRA_BIT-1:0] a_i,
    input  logic [BIT_WIDTH+EXTRA_BIT-1:0] b_i,
    output logic                           lt_o
);

    localparam int W = BIT_WIDTH + EXTRA_BIT;

    logic [EXC_W-1:0] w_exc_a;
    logic [EXC_W-1:0] w_exc_b;
    logic             w_unused_signs;

    assign w_exc_a = a_i[W-1 -: EXC_W];
    assign w_exc_b = b_i[W-1 -: EXC_W];

    // Callers only compare values already screened as non-negative, so the
    // sign bits play no part in the ordering.
    assign w_unused_signs = a_i[BIT_WIDTH-1] ^ b_i[BIT_WIDTH-1];

    always_comb begin
        lt_o = 1'b0;
        if ((w_exc_a != EXC_NAN) && (w_exc_b != EXC_NAN)) begin
            if (w_exc_a != w_exc_b) begin
                // Encodings 00/01/10 already rank zero < normal < inf.
                lt_o = (w_exc_a < w_exc_b);
            end else if (w_exc_a == EXC_NORMAL) begin
                lt_o = (a_i[BIT_WIDTH-2:0] < b_i[BIT_WIDTH-2:0]);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/training_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : training_sequencer                                            |
// | Purpose  : Epoch-level Manhattan-update training engine. Each epoch it   |
// |            takes the layer error, tracks the best error, halves eta on   |
// |            stalled progress, then walks NUMBER_WEIGHTS weights applying  |
// |            new = old - sign(delta)*eta through a shared FloPoCo adder.   |
// | Ports    : start/squared_error/error_valid/err_threshold  - control in   |
// |            mem_rd_en/mem_addr/mem_old_weight/mem_delta     - mem read    |
// |            mem_wr_en/mem_wr_data                           - mem write   |
// |            add_a/add_b/add_valid/add_result                - adder       |
// |            busy/epoch_done/best_snapshot/training_done/training_fault,   |
// |            best_error/eta_out/epoch_count                  - status      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module training_sequencer
    import training_sequencer_pkg::*;
#(
    parameter int                                BIT_WIDTH      = DEF_BIT_WIDTH,
    parameter int                                EXTRA_BIT      = DEF_EXTRA_BIT,
    parameter int                                NUMBER_WEIGHTS = 4,
    parameter int                                ADDR_W         = 2,
    parameter int                                ADD_LATENCY    = 2,
    parameter int                                EPOCH_W        = 16,
    parameter int                                MAX_EPOCHS     = 1024,
    parameter int                                PATIENCE       = 4,
    parameter logic [BIT_WIDTH+EXTRA_BIT-1:0]    ETA_INIT       = FP_ETA_INIT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [BIT_WIDTH+EXTRA_BIT-1:0] squared_error,
    input  logic                           error_valid,
    input  logic [BIT_WIDTH+EXTRA_BIT-1:0] err_threshold,
    output logic                           mem_rd_en,
    output logic [ADDR_W-1:0]              mem_addr,
    input  logic [BIT_WIDTH+EXTRA_BIT-1:0] mem_old_weight,
    input  logic [BIT_WIDTH+EXTRA_BIT-1:0] mem_delta,
    output logic                           mem_wr_en,
    output logic [BIT_WIDTH+EXTRA_BIT-1:0] mem_wr_data,
    output logic [BIT_WIDTH+EXTRA_BIT-1:0] add_a,
    output logic [BIT_WIDTH+EXTRA_BIT-1:0] add_b,
    output logic                           add_valid,
    input  logic [BIT_WIDTH+EXTRA_BIT-1:0] add_result,
    output logic                           busy,
    output logic                           epoch_done,
    output logic                           best_snapshot,
    output logic                           training_done,
    output logic                           training_fault,
    output logic [BIT_WIDTH+EXTRA_BIT-1:0] best_error,
    output logic [BIT_WIDTH+EXTRA_BIT-1:0] eta_out,
    output logic [EPOCH_W-1:0]             epoch_count
);

    localparam int W       = BIT_WIDTH + EXTRA_BIT;
    localparam int SIGN_B  = BIT_WIDTH - 1;
    localparam int EXP_HI  = BIT_WIDTH - 2;
    localparam int EXP_LO  = BIT_WIDTH - 1 - EXP_W;
    localparam int STALL_W = $clog2(PATIENCE + 1);
    localparam int CNT_W   = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;

    localparam logic [W-1:0]       POS_INF   = {EXC_INF, {BIT_WIDTH{1'b0}}};
    localparam logic [ADDR_W-1:0]  LAST_IDX  = ADDR_W'(NUMBER_WEIGHTS - 1);
    localparam logic [STALL_W-1:0] STALL_TOP = STALL_W'(PATIENCE - 1);
    localparam logic [EPOCH_W-1:0] EPOCH_LIM = EPOCH_W'(MAX_EPOCHS);
    localparam logic [EXP_W-1:0]   EXP_ONE   = EXP_W'(1);

    state_t              state_q,      state_d;
    logic [ADDR_W-1:0]   index_q,      index_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [STALL_W-1:0]  stall_q,      stall_d;
    logic [EPOCH_W-1:0]  epoch_q,      epoch_d;
    logic [W-1:0]        best_q,       best_d;
    logic [W-1:0]        eta_q,        eta_d;
    logic [W-1:0]        wr_data_q,    wr_data_d;
    logic                fault_q,      fault_d;
    logic                epoch_done_q, epoch_done_d;
    logic                snap_q,       snap_d;

    logic                w_err_lt_best;
    logic                w_err_lt_thr;
    logic                w_err_fault;
    logic [EXC_W-1:0]    w_err_exc;
    logic [EXC_W-1:0]    w_delta_exc;
    logic                w_unused_delta;

    flopoco_lt #(
        .BIT_WIDTH (BIT_WIDTH),
        .EXTRA_BIT (EXTRA_BIT)
    ) u_lt_best (
        .a_i  (squared_error),
        .b_i  (best_q),
        .lt_o (w_err_lt_best)
    );

    flopoco_lt #(
        .BIT_WIDTH (BIT_WIDTH),
        .EXTRA_BIT (EXTRA_BIT)
    ) u_lt_thr (
        .a_i  (squared_error),
        .b_i  (err_threshold),
        .lt_o (w_err_lt_thr)
    );

    assign w_err_exc   = squared_error[W-1 -: EXC_W];
    assign w_delta_exc = mem_delta[W-1 -: EXC_W];
    // Only the gradient's tag and sign steer the update; magnitude is unused.
    assign w_unused_delta = ^mem_delta[BIT_WIDTH-2:0];

    // A squared error can never legitimately be inf, NaN or negative.
    assign w_err_fault = (w_err_exc == EXC_INF) || (w_err_exc == EXC_NAN) ||
                         ((w_err_exc == EXC_NORMAL) && squared_error[SIGN_B]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            cnt_q        <= '0;
            stall_q      <= '0;
            epoch_q      <= '0;
            best_q       <= POS_INF;
            eta_q        <= ETA_INIT;
            wr_data_q    <= '0;
            fault_q      <= 1'b0;
            epoch_done_q <= 1'b0;
            snap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            cnt_q        <= cnt_d;
            stall_q      <= stall_d;
            epoch_q      <= epoch_d;
            best_q       <= best_d;
            eta_q        <= eta_d;
            wr_data_q    <= wr_data_d;
            fault_q      <= fault_d;
            epoch_done_q <= epoch_done_d;
            snap_q       <= snap_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        cnt_d        = cnt_q;
        stall_d      = stall_q;
        epoch_d      = epoch_q;
        best_d       = best_q;
        eta_d        = eta_q;
        wr_data_d    = wr_data_q;
        fault_d      = fault_q;
        epoch_done_d = 1'b0;
        snap_d       = 1'b0;

        mem_rd_en    = 1'b0;
        mem_wr_en    = 1'b0;
        mem_addr     = '0;
        add_a        = '0;
        add_b        = '0;
        add_valid    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_WAIT_ERR;
                    epoch_d = '0;
                    stall_d = '0;
                    best_d  = POS_INF;
                    fault_d = 1'b0;
                    eta_d   = ETA_INIT;
                end
            end

            ST_WAIT_ERR: begin
                if (error_valid) begin
                    if (w_err_fault) begin
                        fault_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        if (w_err_lt_best) begin
                            best_d  = squared_error;
                            snap_d  = 1'b1;
                            stall_d = '0;
                        end else if (stall_q == STALL_TOP) begin
                            // Patience exhausted: halve eta by dropping the
                            // exponent, but never into the subnormal range.
                            stall_d = '0;
                            if (eta_q[EXP_HI:EXP_LO] != EXP_ONE) begin
                                eta_d[EXP_HI:EXP_LO] = eta_q[EXP_HI:EXP_LO] - EXP_ONE;
                            end
                        end else begin
                            stall_d = stall_q + STALL_W'(1);
                        end

                        if (w_err_lt_thr || (epoch_q == EPOCH_LIM)) begin
                            state_d = ST_DONE;
                        end else begin
                            index_d = '0;
                            state_d = ST_READ;
                        end
                    end
                end
            end

            ST_READ: begin
                mem_rd_en = 1'b1;
                mem_addr  = index_q;
                state_d   = ST_ISSUE;
            end

            ST_ISSUE: begin
                if (w_delta_exc == EXC_ZERO) begin
                    // Zero gradient leaves the weight as is; skip the adder.
                    wr_data_d = mem_old_weight;
                    state_d   = ST_WRITE;
                end else begin
                    add_a     = mem_old_weight;
                    add_b     = {EXC_NORMAL, ~mem_delta[SIGN_B], eta_q[BIT_WIDTH-2:0]};
                    add_valid = 1'b1;
                    // Result is valid ADD_LATENCY cycles after issue, i.e. in
                    // the last of ADD_LATENCY cycles spent in WAIT_ADD.
                    cnt_d     = CNT_W'(ADD_LATENCY - 1);
                    state_d   = ST_WAIT_ADD;
                end
            end

            ST_WAIT_ADD: begin
                if (cnt_q == '0) begin
                    wr_data_d = add_result;
                    state_d   = ST_WRITE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_WRITE: begin
                mem_wr_en = 1'b1;
                mem_addr  = index_q;
                if (index_q == LAST_IDX) begin
                    epoch_done_d = 1'b1;
                    if (epoch_q != '1) begin
                        epoch_d = epoch_q + EPOCH_W'(1);
                    end
                    state_d = ST_WAIT_ERR;
                end else begin
                    index_d = index_q + ADDR_W'(1);
                    state_d = ST_READ;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_wr_data    = wr_data_q;
    assign busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign epoch_done     = epoch_done_q;
    assign best_snapshot  = snap_q;
    assign training_done  = (state_q == ST_DONE);
    assign training_fault = fault_q;
    assign best_error     = best_q;
    assign eta_out        = eta_q;
    assign epoch_count    = epoch_q;

endmodule
`default_nettype wire

// File: tb/tb_training_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_training_sequencer                                         |
// | Purpose  : Self-checking bench for training_sequencer with a memory and  |
// |            fixed-latency adder responder and a real-valued error model.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_training_sequencer;

    localparam int BW   = 32;
    localparam int EB   = 2;
    localparam int W    = BW + EB;
    localparam int NW   = 4;
    localparam int AW   = 2;
    localparam int AL   = 2;
    localparam int EW   = 16;
    localparam int MAXE = 1024;
    localparam int PAT  = 4;

    localparam logic [W-1:0] ETA0  = {2'b01, 32'h3DCCCCCD};
    localparam logic [W-1:0] ETA05 = {2'b01, 32'h3D4CCCCD};
    localparam logic [W-1:0] PINF  = {2'b10, 32'h0};
    localparam logic [W-1:0] F1_0  = {2'b01, 32'h3F800000};
    localparam logic [W-1:0] F0_5  = {2'b01, 32'h3F000000};
    localparam logic [W-1:0] F0_6  = {2'b01, 32'h3F19999A};
    localparam logic [W-1:0] F0_01 = {2'b01, 32'h3C23D70A};
    localparam logic [W-1:0] F0_005= {2'b01, 32'h3BA3D70A};
    localparam logic [W-1:0] FNAN  = {2'b11, 32'h7FC00000};
    localparam logic [W-1:0] FNEG  = {2'b01, 32'hBF000000};

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  squared_error;
    logic          error_valid;
    logic [W-1:0]  err_threshold;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_old_weight;
    logic [W-1:0]  mem_delta;
    logic          mem_wr_en;
    logic [W-1:0]  mem_wr_data;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic          add_valid;
    logic [W-1:0]  add_result;
    logic          busy;
    logic          epoch_done;
    logic          best_snapshot;
    logic          training_done;
    logic          training_fault;
    logic [W-1:0]  best_error;
    logic [W-1:0]  eta_out;
    logic [EW-1:0] epoch_count;

    training_sequencer #(
        .BIT_WIDTH(BW), .EXTRA_BIT(EB), .NUMBER_WEIGHTS(NW), .ADDR_W(AW),
        .ADD_LATENCY(AL), .EPOCH_W(EW), .MAX_EPOCHS(MAXE), .PATIENCE(PAT),
        .ETA_INIT(ETA0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .squared_error(squared_error),
        .error_valid(error_valid), .err_threshold(err_threshold),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_old_weight(mem_old_weight),
        .mem_delta(mem_delta), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .add_a(add_a), .add_b(add_b), .add_valid(add_valid), .add_result(add_result),
        .busy(busy), .epoch_done(epoch_done), .best_snapshot(best_snapshot),
        .training_done(training_done), .training_fault(training_fault),
        .best_error(best_error), .eta_out(eta_out), .epoch_count(epoch_count)
    );

    always #5 clk = ~clk;

    // ---------------- memory and adder responders ----------------
    logic [W-1:0] mem_old [NW];
    logic [W-1:0] mem_dl  [NW];
    logic [W-1:0] pipe    [AL];

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_old_weight <= mem_old[mem_addr];
            mem_delta      <= mem_dl[mem_addr];
        end
        // Stand-in adder: integer sum of the bit patterns, AL cycles late.
        pipe[0] <= add_a + add_b;
        for (int i = 1; i < AL; i++) pipe[i] <= pipe[i-1];
    end
    assign add_result = pipe[AL-1];

    // ---------------- reference model ----------------
    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] m_best, m_eta;
    int           m_stall, m_epoch;
    logic         m_fault;
    logic [W-1:0] obs_best, obs_eta;
    logic         obs_snap;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Numeric value of a non-negative FloPoCo word.
    function automatic real fval(input logic [W-1:0] x);
        logic [7:0]  e;
        logic [22:0] m;
        e = x[30:23];
        m = x[22:0];
        case (x[W-1:W-2])
            2'b00:   return 0.0;
            2'b01:   return (1.0 + real'(m) / 8388608.0) * (2.0 ** (real'(e) - 127.0));
            default: return 1.0e300;
        endcase
    endfunction

    function automatic logic [W-1:0] halve(input logic [W-1:0] e);
        logic [W-1:0] r;
        r = e;
        if (e[30:23] > 8'd1) r[30:23] = e[30:23] - 8'd1;
        return r;
    endfunction

    task automatic fill_mem(input int zero_idx, input bit rand_zero);
        for (int i = 0; i < NW; i++) begin
            mem_old[i] = {2'b01, 1'($urandom), 8'($urandom_range(100, 140)), 23'($urandom)};
            if (i == zero_idx || (rand_zero && $urandom_range(0, 3) == 0))
                mem_dl[i] = {2'b00, 32'h0};
            else
                mem_dl[i] = {2'b01, 32'($urandom)};
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd_en"}, mem_rd_en, 0);
        chk({tag, "_wr_en"}, mem_wr_en, 0);
        chk({tag, "_add_valid"}, add_valid, 0);
        chk({tag, "_epoch_done"}, epoch_done, 0);
        chk({tag, "_snapshot"}, best_snapshot, 0);
        chk({tag, "_done"}, training_done, 0);
        chk({tag, "_fault"}, training_fault, 0);
        chk({tag, "_best"}, best_error, PINF);
        chk({tag, "_eta"}, eta_out, ETA0);
        chk({tag, "_epoch"}, epoch_count, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wr_data"}, mem_wr_data, 0);
        chk({tag, "_add_a"}, add_a, 0);
        chk({tag, "_add_b"}, add_b, 0);
    endtask

    // Called at a negedge while the DUT is idle or done.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_best = PINF; m_eta = ETA0; m_stall = 0; m_epoch = 0; m_fault = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_epoch", epoch_count, 0);
        chk("start_eta", eta_out, ETA0);
        chk("start_best", best_error, PINF);
        chk("start_done", training_done, 0);
        chk("start_fault", training_fault, 0);
    endtask

    // Called at a negedge while the DUT waits for an error.
    task automatic do_epoch(input logic [W-1:0] err, input bit poke);
        bit           snap, stop, seen;
        int           total, nzero_adds, rd_i, wr_i, nadd, nrd, ri, wi;
        logic [W-1:0] expb [NW];
        logic [W-1:0] expw;

        squared_error = err;
        error_valid   = 1'b1;
        @(negedge clk);
        error_valid   = 1'b0;

        snap = 1'b0;
        stop = 1'b0;
        if (err[W-1:W-2] >= 2'b10 || (err[W-1:W-2] == 2'b01 && err[31])) begin
            m_fault = 1'b1;
            stop    = 1'b1;
        end else begin
            if (fval(err) < fval(m_best)) begin
                m_best = err; snap = 1'b1; m_stall = 0;
            end else begin
                m_stall++;
                if (m_stall == PAT) begin
                    m_eta   = halve(m_eta);
                    m_stall = 0;
                end
            end
            if (fval(err) < fval(err_threshold) || m_epoch == MAXE) stop = 1'b1;
        end
        obs_best = best_error;
        obs_eta  = eta_out;
        obs_snap = best_snapshot;
        chk("best_error", best_error, m_best);
        chk("best_snapshot", best_snapshot, snap);
        chk("eta_out", eta_out, m_eta);
        chk("training_fault", training_fault, m_fault);

        if (stop) begin
            chk("training_done", training_done, 1);
            chk("done_busy", busy, 0);
            nrd = 0;
            for (int c = 0; c < 6; c++) begin
                if (mem_rd_en) nrd++;
                @(negedge clk);
            end
            chk("reads_after_done", nrd, 0);
            return;
        end

        total = 0;
        nzero_adds = 0;
        for (int i = 0; i < NW; i++) begin
            if (mem_dl[i][W-1:W-2] == 2'b00) begin
                expb[i] = '0;
                total  += 3;
            end else begin
                // Step of magnitude eta, signed opposite to the gradient.
                expb[i]     = m_eta;
                expb[i][31] = ~mem_dl[i][31];
                total      += 3 + AL;
                nzero_adds++;
            end
        end

        rd_i = 0; wr_i = 0; nadd = 0; seen = 1'b0;
        for (int cyc = 1; cyc <= 200 && !seen; cyc++) begin
            start = (poke && cyc == 3);
            if (mem_rd_en) begin
                chk("rd_addr", mem_addr, rd_i);
                rd_i++;
            end
            if (add_valid) begin
                ri = (rd_i > 0) ? rd_i - 1 : 0;
                chk("add_a", add_a, mem_old[ri]);
                chk("add_b", add_b, expb[ri]);
                nadd++;
            end
            if (mem_wr_en) begin
                wi   = (wr_i < NW) ? wr_i : NW - 1;
                expw = (mem_dl[wi][W-1:W-2] == 2'b00) ? mem_old[wi] : mem_old[wi] + expb[wi];
                chk("wr_addr", mem_addr, wr_i);
                chk("wr_data", mem_wr_data, expw);
                wr_i++;
            end
            if (epoch_done) begin
                seen = 1'b1;
                if (m_epoch < (1 << EW) - 1) m_epoch++;
                chk("epoch_cycles", cyc, total + 1);
                chk("epoch_reads", rd_i, NW);
                chk("epoch_writes", wr_i, NW);
                chk("epoch_adds", nadd, nzero_adds);
                chk("epoch_count", epoch_count, m_epoch);
            end else begin
                @(negedge clk);
            end
        end
        start = 1'b0;
        chk("epoch_done_seen", seen, 1);
    endtask

    typedef struct {
        logic [W-1:0] err;
        logic [W-1:0] exp_best;
        logic [W-1:0] exp_eta;
        logic         exp_snap;
    } vec_t;

    vec_t tab [5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nwr, got;

        tab[0] = '{F0_5, F0_5, ETA0,  1'b1};
        tab[1] = '{F0_6, F0_5, ETA0,  1'b0};
        tab[2] = '{F0_6, F0_5, ETA0,  1'b0};
        tab[3] = '{F0_6, F0_5, ETA0,  1'b0};
        tab[4] = '{F0_6, F0_5, ETA05, 1'b0};

        rst = 1'b1; start = 1'b0; error_valid = 1'b0;
        squared_error = '0; err_threshold = '0;
        mem_old_weight = '0; mem_delta = '0;
        for (int i = 0; i < AL; i++) pipe[i] = '0;
        fill_mem(-1, 1'b0);
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // First epoch: error 1.0, zero gradient on weight 2.
        do_start();
        fill_mem(2, 1'b0);
        do_epoch(F1_0, 1'b0);
        chk("e1_best", obs_best, F1_0);
        chk("e1_snap", obs_snap, 1);
        chk("e1_epoch_count", epoch_count, 1);

        // Stall / eta halving table.
        for (int k = 0; k < 5; k++) begin
            fill_mem(-1, 1'b1);
            do_epoch(tab[k].err, 1'b0);
            chk("tab_best", obs_best, tab[k].exp_best);
            chk("tab_eta", obs_eta, tab[k].exp_eta);
            chk("tab_snap", obs_snap, tab[k].exp_snap);
        end

        // Random epochs; one carries an ignored start pulse mid-epoch.
        for (int k = 0; k < 12; k++) begin
            fill_mem(-1, 1'b1);
            do_epoch({2'b01, 1'b0, 8'($urandom_range(124, 126)), 23'($urandom)}, k == 5);
        end

        // Threshold stop, then restart.
        err_threshold = F0_01;
        do_epoch(F0_005, 1'b0);
        do_start();
        fill_mem(-1, 1'b1);
        do_epoch(F1_0, 1'b0);

        // NaN and negative errors fault without touching best_error.
        do_epoch(FNAN, 1'b0);
        chk("nan_best_kept", best_error, F1_0);
        do_start();
        do_epoch(FNEG, 1'b0);
        chk("neg_best_kept", best_error, PINF);

        // Reset while waiting on the adder.
        do_start();
        fill_mem(-1, 1'b0);
        squared_error = F1_0;
        error_valid   = 1'b1;
        @(negedge clk);
        error_valid   = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            if (add_valid) got = 1;
            else @(negedge clk);
        end
        chk("reach_wait_add", got, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outputs("abort");
        nwr = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 2) rst = 1'b0;
            if (mem_wr_en) nwr++;
        end
        chk("aborted_write", nwr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
